// File: rtl/glitch_test_sequencer.sv
// Streams seed+k operands into the pipeline under test, checks each result LATENCY+1 edges after it is driven,
// and counts mismatches. One operand per cycle with no backpressure; abort is the only way to stop a run early.
module glitch_test_sequencer #(
    parameter int DATA_W  = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic              glitched_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_vec,
    output logic [DATA_W-1:0] dut_a,
    input  logic [DATA_W:0]   dut_sum,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic              first_fault_valid,
    output logic [DATA_W-1:0] first_fault_vec
);

    localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   vec_idx;
    logic [DRN_W-1:0]   drain_cnt;
    logic [LATENCY-1:0] tag_vld;
    logic [DATA_W:0]    tag_exp [LATENCY];

    logic accept;
    logic run_abort;
    logic tail_mismatch;

    assign accept        = (state == IDLE) && start && !abort;
    assign run_abort     = abort && ((state == RUN) || (state == DRAIN));
    assign tail_mismatch = tag_vld[LATENCY-1] && (dut_sum != tag_exp[LATENCY-1]);

    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            num_q     <= '0;
            vec_idx   <= '0;
            drain_cnt <= '0;
            dut_a     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        num_q   <= num_vec;
                        vec_idx <= '0;
                        if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            dut_a <= seed;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        dut_a <= '0;
                    end else if (vec_idx == num_q - CNT_W'(1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        dut_a     <= '0;
                    end else begin
                        vec_idx <= vec_idx + CNT_W'(1);
                        dut_a   <= dut_a + DATA_W'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == DRN_W'(LATENCY - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    dut_a <= '0;
                end
            endcase
        end
    end

    // The tag is captured from the operand currently on dut_a, so a LATENCY-deep
    // shift lines its tail up with the pipeline output one edge later.
    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_exp[i] <= '0;
            end
        end else if (run_abort) begin
            tag_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_exp[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_exp[i] <= tag_exp[i-1];
            end
            tag_vld[0] <= (state == RUN);
            tag_exp[0] <= {1'b0, dut_a};
        end
    end

    always_ff @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            fault_cnt         <= '0;
            first_fault_valid <= 1'b0;
            first_fault_vec   <= '0;
        end else if (accept) begin
            fault_cnt         <= '0;
            first_fault_valid <= 1'b0;
            first_fault_vec   <= '0;
        end else if (!run_abort && tail_mismatch) begin
            if (fault_cnt != {CNT_W{1'b1}}) begin
                fault_cnt <= fault_cnt + CNT_W'(1);
            end
            if (!first_fault_valid) begin
                first_fault_valid <= 1'b1;
                first_fault_vec   <= tag_exp[LATENCY-1][DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_glitch_test_sequencer.sv
// Randomised and directed runs against a list-based reference; a negedge monitor scores
// every operand while busy and the result fields on each done pulse.
module tb_glitch_test_sequencer;

    localparam int DATA_W  = 4;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 8;

    logic              glitched_clk = 1'b0;
    logic              rst          = 1'b1;
    logic              start        = 1'b0;
    logic              abort        = 1'b0;
    logic [DATA_W-1:0] seed         = '0;
    logic [CNT_W-1:0]  num_vec      = '0;
    logic [DATA_W-1:0] dut_a;
    logic [DATA_W:0]   dut_sum;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  fault_cnt;
    logic              first_fault_valid;
    logic [DATA_W-1:0] first_fault_vec;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cnt;
        int ffv;
        int ffvec;
        int cycles;
    } res_t;

    int   qa[$];
    res_t qr[$];
    bit   skip    = 1'b0;
    bit   bad_all = 1'b0;
    bit   bad[16];
    logic [DATA_W:0] p1, p2;

    glitch_test_sequencer #(.DATA_W(DATA_W), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
        .glitched_clk      (glitched_clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .seed              (seed),
        .num_vec           (num_vec),
        .dut_a             (dut_a),
        .dut_sum           (dut_sum),
        .busy              (busy),
        .done              (done),
        .fault_cnt         (fault_cnt),
        .first_fault_valid (first_fault_valid),
        .first_fault_vec   (first_fault_vec)
    );

    always #5 glitched_clk = ~glitched_clk;

    // Two-stage pipeline under test: identity, with the top bit set on operands marked bad.
    always @(posedge glitched_clk or negedge rst) begin
        if (!rst) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= (bad_all || bad[dut_a]) ? {1'b1, dut_a} : {1'b0, dut_a};
            p2 <= p1;
        end
    end
    assign dut_sum = p2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor
    int   busy_cyc  = 0;
    bit   prev_done = 1'b0;
    res_t mr;
    int   me;
    initial begin
        forever begin
            @(negedge glitched_clk);
            if (rst) begin
                if (!busy) chk("idle_dut_a", int'(dut_a), 0);
                if (busy && !skip) begin
                    busy_cyc++;
                    if (qa.size() == 0) fail("unexpected_busy");
                    else begin
                        me = qa.pop_front();
                        chk("dut_a", int'(dut_a), me);
                    end
                end
                if (done) begin
                    chk("done_one_cycle", int'(prev_done), 0);
                    if (skip) fail("unexpected_done");
                    else if (qr.size() == 0) fail("done_without_run");
                    else begin
                        mr = qr.pop_front();
                        chk("fault_cnt", int'(fault_cnt), mr.cnt);
                        chk("first_fault_valid", int'(first_fault_valid), mr.ffv);
                        if (mr.ffv != 0) chk("first_fault_vec", int'(first_fault_vec), mr.ffvec);
                        chk("busy_cycles", busy_cyc, mr.cycles);
                        chk("operands_left", qa.size(), 0);
                    end
                    busy_cyc = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic clear_bad();
        bad_all = 1'b0;
        for (int i = 0; i < 16; i++) bad[i] = 1'b0;
    endtask

    // Reference: operand list is seed+k mod 16; faults are the operands marked bad.
    task automatic run_seq(input int s, input int n, input bit hold);
        logic [DATA_W-1:0] op;
        res_t r;
        bit got;
        r.cnt = 0; r.ffv = 0; r.ffvec = 0;
        for (int k = 0; k < n; k++) begin
            op = DATA_W'(s + k);
            qa.push_back(int'(op));
            if (bad_all || bad[op]) begin
                if (r.ffv == 0) begin
                    r.ffv   = 1;
                    r.ffvec = int'(op);
                end
                if (r.cnt < 255) r.cnt++;
            end
        end
        if (n > 0) repeat (LATENCY) qa.push_back(0);
        r.cycles = (n > 0) ? n + LATENCY : 0;
        qr.push_back(r);
        @(negedge glitched_clk);
        seed    = DATA_W'(s);
        num_vec = CNT_W'(n);
        start   = 1'b1;
        got     = 1'b0;
        for (int i = 0; i < n + LATENCY + 8 && !got; i++) begin
            @(negedge glitched_clk);
            if (!hold) start = 1'b0;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) fail("done_timeout");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_bad();
        #3 rst = 1'b0;
        #4;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dut_a", int'(dut_a), 0);
        chk("rst_fault_cnt", int'(fault_cnt), 0);
        chk("rst_ffv", int'(first_fault_valid), 0);
        chk("rst_ffvec", int'(first_fault_vec), 0);
        @(negedge glitched_clk);
        rst = 1'b1;

        run_seq(3, 5, 1'b0);
        run_seq(14, 4, 1'b0);
        bad[6] = 1'b1;
        bad[9] = 1'b1;
        run_seq(4, 8, 1'b0);
        clear_bad();
        bad_all = 1'b1;
        run_seq(0, 255, 1'b0);
        clear_bad();
        run_seq(7, 0, 1'b0);
        bad[2] = 1'b1;
        run_seq(12, 9, 1'b1);
        clear_bad();

        // Abort during RUN: only operand 0 is bad, and it is compared before the abort edge.
        skip   = 1'b1;
        bad[5] = 1'b1;
        @(negedge glitched_clk);
        seed = 4'd5; num_vec = 8'd10; start = 1'b1;
        @(negedge glitched_clk);
        start = 1'b0;
        repeat (3) @(negedge glitched_clk);
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge glitched_clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dut_a", int'(dut_a), 0);
        chk("abort_fault_cnt", int'(fault_cnt), 1);
        chk("abort_ffv", int'(first_fault_valid), 1);
        chk("abort_ffvec", int'(first_fault_vec), 5);
        repeat (14) @(negedge glitched_clk);

        // abort and start together in IDLE: start is dropped, results stay readable.
        seed = 4'd1; num_vec = 8'd3; start = 1'b1; abort = 1'b1;
        @(negedge glitched_clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", int'(busy), 0);
        chk("abort_start_done", int'(done), 0);
        chk("retained_fault_cnt", int'(fault_cnt), 1);
        repeat (6) @(negedge glitched_clk);
        clear_bad();
        skip = 1'b0;

        for (int r = 0; r < 25; r++) begin
            clear_bad();
            if ($urandom_range(0, 9) == 0) bad_all = 1'b1;
            for (int i = 0; i < 16; i++) bad[i] = ($urandom_range(0, 3) == 0);
            run_seq(int'($urandom_range(0, 15)), int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)));
        end
        clear_bad();

        // Asynchronous reset while in DRAIN.
        skip    = 1'b1;
        bad_all = 1'b1;
        @(negedge glitched_clk);
        seed = 4'd1; num_vec = 8'd3; start = 1'b1;
        @(negedge glitched_clk);
        start = 1'b0;
        repeat (3) @(negedge glitched_clk);
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_fault_cnt", int'(fault_cnt), 1);
        #2 rst = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_done", int'(done), 0);
        chk("midrun_rst_dut_a", int'(dut_a), 0);
        chk("midrun_rst_fault_cnt", int'(fault_cnt), 0);
        chk("midrun_rst_ffv", int'(first_fault_valid), 0);
        chk("midrun_rst_ffvec", int'(first_fault_vec), 0);
        @(negedge glitched_clk);
        rst = 1'b1;
        clear_bad();
        repeat (8) @(negedge glitched_clk);
        skip = 1'b0;
        chk("queue_drained", qr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitch_test_sequencer.md
# glitch_test_sequencer

Sequencer for the clock-glitch characterisation datapath. Streams a programmable run of test operands into the two-stage registered pipeline under test, tags each issued operand with its expected result, and compares the pipeline output at the known latency. Mismatches caused by glitched clock edges are counted and the first failing operand is captured for readout.

## Interface
Parameters:
- DATA_W, 4, operand width driven into the pipeline; pipeline result is DATA_W+1 bits
- LATENCY, 2, cycles from operand driven to result valid at dut_sum (≥1)
- CNT_W, 8, width of vector-count and fault-count fields

Ports:
- glitched_clk  in  1  sole clock for the block and the pipeline under test
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous abort of a run in progress
- seed  in  DATA_W  first operand of the run; sampled with start
- num_vec  in  CNT_W  number of operands to issue; sampled with start
- dut_a  out  DATA_W  operand to pipeline input
- dut_sum  in  DATA_W+1  pipeline output
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of a completed run
- fault_cnt  out  CNT_W  mismatches in current/last run, saturating
- first_fault_valid  out  1  at least one mismatch captured this run
- first_fault_vec  out  DATA_W  operand whose result first mismatched

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches seed, num_vec; clears fault_cnt, first_fault_valid, first_fault_vec. num_vec≠0 → RUN; num_vec=0 → DONE directly (no operands issued).
- RUN: each cycle drives dut_a = seed + k (mod 2^DATA_W), k = 0..num_vec-1; pushes {valid=1, exp={1'b0, dut_a}} into a LATENCY-deep tag shift register. After operand num_vec-1 is driven → DRAIN.
- DRAIN: pushes valid=0 tags; stays LATENCY cycles, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- dut_a = 0 whenever not in RUN; tags pushed outside RUN have valid=0.
- Check: every edge, if tail tag valid and dut_sum ≠ tail exp: fault_cnt += 1 unless all-ones (saturates); if first_fault_valid=0, set it and load first_fault_vec = exp[DATA_W-1:0].
- Operand wrap: seed + k wraps modulo 2^DATA_W with no effect on the run.
- start while busy or in DONE: ignored.
- abort=1 in RUN or DRAIN: → IDLE next edge, tag register cleared, no done pulse; fault_cnt and first_fault_* retain values. abort in IDLE/DONE: no effect. abort and start together in IDLE: abort wins (start ignored).
- Results remain readable in IDLE until next accepted start.

## Timing
- Reset (async assert, any state): state=IDLE, dut_a=0, busy=0, done=0, fault_cnt=0, first_fault_valid=0, first_fault_vec=0, all tags invalid. Reset mid-run discards the run.
- Edge E0 samples start in IDLE; operand k is on dut_a during the cycle after edge E0+k; its result is compared at edge E0+k+1+LATENCY.
- busy rises the cycle after E0 and stays high for num_vec+LATENCY cycles; done pulses in the following cycle. Total start-to-done: num_vec+LATENCY+1 edges.
- num_vec=0: done pulses the cycle after E0; busy never asserts.
- fault_cnt/first_fault_* update on the same edge as the compare; final values are stable when done is high.

## Test plan
- Clean pipeline, seed=3, num_vec=5 → dut_a 3,4,5,6,7; done at cycle 8 after start; fault_cnt=0, first_fault_valid=0.
- Wrap: seed=14, num_vec=4 → dut_a 14,15,0,1; no faults; expected results 5'd14,15,0,1.
- Injected fault: bench forces dut_sum=5'd0 when the compare for operand 6 occurs (seed=4, num_vec=8) → fault_cnt=1, first_fault_vec=6; second forced error on operand 9 → fault_cnt=2, first_fault_vec stays 6.
- Saturation: CNT_W=8, num_vec=255, dut_sum forced constant wrong → fault_cnt=255 at done, no wrap.
- num_vec=0 → done one cycle after start, busy stays 0, dut_a stays 0; start held high during a run → ignored, run length unchanged.
- abort in cycle 3 of RUN → IDLE next edge, no done; async rst asserted mid-DRAIN → all outputs to reset values immediately.
